// File: rtl/bit_deserializer_32.sv
// bit_deserializer_32: serial-to-parallel converter.
// Bits arrive one per cycle on a valid/ready handshake and are steered into a
// 32-bit assembly register at a counter-selected index. Completed words are
// presented on a valid/ready output port. When the output slot is still
// occupied as the 32nd bit arrives, the word parks in the assembly register
// (count == 32) and input is throttled until the slot frees up.
module bit_deserializer_32 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_sof,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [5:0]  fill_count,
  output logic        err_partial
);

  localparam logic [5:0] COUNT_FULL = 6'd32;
  localparam logic [5:0] COUNT_LAST = 6'd31;
  localparam logic [4:0] FIRST_IDX  = LSB_FIRST ? 5'd0 : 5'd31;

  logic [5:0]  count_reg, count_next;
  logic [31:0] asm_reg, asm_next;
  logic [31:0] word_out_reg, word_out_next;
  logic        word_valid_reg, word_valid_next;
  logic        err_reg, err_next;

  logic        accept;
  logic        out_free;
  logic [4:0]  wr_idx;
  logic [31:0] asm_ins;

  // bit_ready depends on state only, so word_ready never reaches it combinationally
  assign bit_ready = (count_reg != COUNT_FULL);
  assign accept    = bit_valid & bit_ready;
  assign out_free  = ~word_valid_reg | word_ready;

  // Write index: a start-of-word bit always lands at the first-bit position
  always_comb begin
    wr_idx = FIRST_IDX;
    if (!bit_sof) begin
      if (LSB_FIRST) begin
        wr_idx = count_reg[4:0];
      end else begin
        wr_idx = 5'd31 - count_reg[4:0];
      end
    end
  end

  // 1:32 demux: assembly register with the incoming bit inserted at wr_idx
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_demux
      assign asm_ins[gi] = (wr_idx == 5'(gi)) ? bit_in : asm_reg[gi];
    end
  endgenerate

  // Next-state logic: word hand-off, bit accept, start-of-word resync
  always_comb begin
    count_next      = count_reg;
    asm_next        = asm_reg;
    word_out_next   = word_out_reg;
    word_valid_next = word_valid_reg;
    err_next        = 1'b0;

    // A consumed word empties the slot unless a new word loads below
    if (word_valid_reg && word_ready) begin
      word_valid_next = 1'b0;
    end

    if (count_reg == COUNT_FULL) begin
      // Parked: release the finished word as soon as the slot is free
      if (out_free) begin
        word_out_next   = asm_reg;
        word_valid_next = 1'b1;
        count_next      = 6'd0;
      end
    end else if (accept) begin
      asm_next = asm_ins;
      if (bit_sof) begin
        count_next = 6'd1;
        err_next   = (count_reg != 6'd0);
      end else if (count_reg == COUNT_LAST) begin
        if (out_free) begin
          // Load straight from the insert path so there is no bubble
          word_out_next   = asm_ins;
          word_valid_next = 1'b1;
          count_next      = 6'd0;
        end else begin
          count_next = COUNT_FULL;
        end
      end else begin
        count_next = count_reg + 6'd1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg      <= 6'd0;
      asm_reg        <= 32'd0;
      word_out_reg   <= 32'd0;
      word_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      count_reg      <= count_next;
      asm_reg        <= asm_next;
      word_out_reg   <= word_out_next;
      word_valid_reg <= word_valid_next;
      err_reg        <= err_next;
    end
  end

  assign word_out    = word_out_reg;
  assign word_valid  = word_valid_reg;
  assign fill_count  = count_reg;
  assign err_partial = err_reg;

endmodule

// File: doc/bit_deserializer_32.md
Name: bit_deserializer_32

Overview:
- Serial-to-parallel converter; the write-direction counterpart of the 32:1 bit-select path.
- Accepts one bit per cycle over a valid/ready handshake and steers each bit into a 32-bit assembly register at a counter-selected index (a 1:32 demux with storage).
- Presents each completed word on a valid/ready output port.
- Sits between serial sources (scan/debug shift paths, bit-serial test stimulus) and 32-bit datapath consumers.

Parameters:
- LSB_FIRST, 1, 1 = first bit of a word lands at index 0 and later bits ascend; 0 = first bit lands at index 31 and later bits descend.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- bit_in  in  1  serial data bit.
- bit_sof  in  1  start-of-word marker, qualified by bit_valid.
- bit_valid  in  1  bit_in/bit_sof are valid.
- bit_ready  out  1  block can accept a bit this cycle.
- word_out  out  32  assembled word.
- word_valid  out  1  word_out holds an unconsumed word.
- word_ready  in  1  consumer accepts word_out.
- fill_count  out  6  number of bits held in the assembly register, 0..32.
- err_partial  out  1  one-cycle pulse: a partial word was discarded by bit_sof.

Behaviour:
- Reset (synchronous, active-high):
  - count=0, asm=0, word_out=0, word_valid=0, err_partial=0.
  - bit_ready=1 in the first cycle after reset.
  - A partial word in progress is discarded silently, with no err_partial.
- Definitions:
  - accept = bit_valid & bit_ready.
  - out_free = !word_valid | word_ready.
  - bit_ready = (count != 32); combinational from state only, not from bit_valid.
- Index mapping:
  - idx = count[4:0] when LSB_FIRST=1; idx = 31 - count[4:0] when LSB_FIRST=0.
  - On accept, asm[idx] <= bit_in; all other asm bits hold.
- Normal accept (no sof), count 0..30: count <= count+1.
- Accept of the 32nd bit (count==31):
  - If out_free: word_out <= asm with bit inserted; word_valid <= 1; count <= 0. There is no bubble, so sustained throughput is 1 bit/cycle.
  - Else: count <= 32 (parked) and bit_ready drops next cycle.
- Parked state (count==32):
  - Each cycle where out_free: word_out <= asm, word_valid <= 1, count <= 0.
  - bit_ready returns to 1 the following cycle.
- Output handshake:
  - word_valid & word_ready with no new word loading that edge → word_valid <= 0.
  - Consume and load on the same edge → word_valid stays 1 and word_out takes the new word.
  - word_out is held stable while word_valid=1 and word_ready=0.
- bit_sof on accept:
  - The bit is written at the first-bit index (0 if LSB_FIRST, else 31) and count <= 1.
  - If count was 1..31, err_partial=1 for exactly the next cycle.
  - If count was 0, no error.
  - sof while parked cannot occur because bit_ready=0.
- Latency: the word is visible on word_out the cycle after its 32nd bit is accepted, provided out_free at that edge.
- fill_count = count, registered.
- Widths: count is 6 bits; it never exceeds 32 and never wraps.
- bit_valid=0 → no state change apart from the output handshake.
- No combinational path from word_ready to bit_ready.

Test Plan:
- Reset, LSB_FIRST=1, word_ready=1, stream 32 bits of 0xDEADBEEF LSB first with bit_valid held high → word_out=0xDEADBEEF, word_valid=1 for one cycle, exactly 1 cycle after the last accept, fill_count=0.
- LSB_FIRST=0, same bit order as the previous test → word_out=0xF77DB57B (bit-reversed); back-to-back second word 0x00000001 LSB-first stream → word_out=0x80000000 the next word slot, no dead cycle between words.
- word_ready=0 with a word already pending, stream a second full word → after the 32nd bit, fill_count=32 and bit_ready=0. Raise word_ready for one cycle → first word consumed, second loaded same edge (word_valid stays 1), bit_ready=1 next cycle.
- Send 10 bits, then a bit with bit_sof=1, then 31 more bits of 0x12345678 (sof bit = bit0) → err_partial pulses exactly once; word_out=0x12345678; the 10 discarded bits never appear.
- Assert rst after 20 bits accepted and while word_valid=1 → next cycle word_valid=0, word_out=0, fill_count=0, bit_ready=1, err_partial=0. A following 32-bit stream of 0xA5A5A5A5 → output 0xA5A5A5A5.
- Random bit_valid gaps (50%) and random word_ready over 1000 words, compared against a scoreboard → no word lost, duplicated or reordered; word_out stable whenever word_valid=1 and word_ready=0.
